// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared constants and FSM state encoding for the SPI register target
//
// Purpose: state codes for the frame FSM plus command/byte layout constants.
// Ports: none (package).

package spi_target_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RD_BIT = 7;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_WAIT_SS = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_READ    = 3'd4;

endpackage

// File: rtl/spi_target_regs_if.sv
// rtl/spi_target_regs_if.sv - SPI pad and register-bus bundle for spi_target_regs
//
// Purpose: groups the SPI pins and the byte-wide register bus.
// Signals:
//   spi_sck/spi_ss/spi_mosi   initiator -> target pins
//   spi_miso/spi_miso_oe      target -> initiator data and pad enable
//   reg_addr/reg_wdata        register address and write data
//   reg_we/reg_re             1-clk write strobe / read request
//   reg_rdata                 read data, one clk after reg_re
//   busy                      frame in progress
// Modports: slave = the SPI target, master = the pads/register side.

interface spi_target_regs_if #(
  parameter int ADDR_W = 7
) ();
  import spi_target_pkg::*;

  logic              spi_sck;
  logic              spi_ss;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [BYTE_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [BYTE_W-1:0] reg_rdata;
  logic              busy;

  modport slave (
    input  spi_sck, spi_ss, spi_mosi, reg_rdata,
    output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output spi_sck, spi_ss, spi_mosi, reg_rdata,
    input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

endinterface

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - multi-flop synchronizer with rise/fall detect for one SPI pin
//
// Purpose: brings an asynchronous pad into the clk domain.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   i_d           raw pad input
//   o_level       synchronized level (last stage)
//   o_rise/o_fall 1-clk pulses from comparing the last two stages

module spi_target_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // r_sync[0] is the first flop; r_sync[STAGES-1] is the oldest sample.
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  =  r_sync[STAGES-2] & ~r_sync[STAGES-1];
  assign o_fall  = ~r_sync[STAGES-2] &  r_sync[STAGES-1];

endmodule

// File: rtl/spi_target_regs.sv
// rtl/spi_target_regs.sv - SPI mode-0 target decoding command/data bytes onto a register bus
//
// Purpose: oversamples SCK/SS/MOSI in clk (>= 8x SCK), decodes a command byte
//   (bit7 = read, low bits = address) and following data bytes into reg_we
//   strobes or reg_re fetches whose data is shifted out on MISO.
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   bus       spi_target_regs_if.slave (SPI pins + register bus)
// Build option: SPI_TARGET_AUTOINC_EN - when defined the address pointer
//   increments after every written byte / read fetch; otherwise it stays at
//   the command address for the whole frame.

module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_target_regs_if.slave      bus
);

`ifdef SPI_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_ss_level,  w_ss_rise,  w_ss_fall;
  logic w_mosi,      w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .i_d(bus.spi_sck),
    .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .i_d(bus.spi_ss),
    .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .i_d(bus.spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sck_level, w_mosi_rise, w_mosi_fall};

  logic [2:0]          r_state;
  logic [2:0]          r_bitcnt;
  logic [BYTE_W-1:0]   r_rx;
  logic [BYTE_W-1:0]   r_tx;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_addr;
  logic [BYTE_W-1:0]   r_wdata;
  logic                r_we;
  logic                r_re;
  logic                r_load;
  logic                r_adv;
  logic [SYNC_STAGES-1:0] r_fill;

  logic              w_active;
  logic              w_ss_hi;
  logic              w_byte_done;
  logic              w_settled;
  logic [BYTE_W-1:0] w_byte;

  assign w_active = (r_state == ST_CMD) || (r_state == ST_WRITE) || (r_state == ST_READ);
  // An SS rise in the same clk as the 8th SCK rise must still abort the byte.
  assign w_ss_hi     = w_ss_level | w_ss_rise;
  assign w_byte_done = w_active && w_sck_rise && (r_bitcnt == 3'd7) && !w_ss_hi;
  assign w_byte      = {r_rx[BYTE_W-2:0], w_mosi};
  // The SS chain resets to "high"; WAIT_SS must not trust it until the chain
  // has been refilled from the pad, or a reset with SS held low would
  // immediately look like a fresh frame.
  assign w_settled   = r_fill[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_WAIT_SS;
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_ptr    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_load   <= 1'b0;
      r_adv    <= 1'b0;
      r_fill   <= '0;
    end else begin
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      // Fetch pipeline: reg_re cycle -> load cycle -> pointer advance.
      r_load <= r_re;
      r_adv  <= r_load;

      if (r_load) begin
        r_tx <= bus.reg_rdata;
      end else if (w_sck_fall && (r_state == ST_READ) && (r_bitcnt != 3'd0)) begin
        // The fall after a byte's last rise (count back at 0) is skipped so
        // the freshly loaded MSB survives until the next byte's first rise.
        r_tx <= {r_tx[BYTE_W-2:0], 1'b0};
      end

      if (r_adv && AUTOINC) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end

      if (w_ss_hi) begin
        r_bitcnt <= '0;
      end else if (w_active && w_sck_rise) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_rx     <= w_byte;
      end

      case (r_state)
        ST_WAIT_SS: begin
          if (w_settled && w_ss_level) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_ss_fall) r_state <= ST_CMD;
        end
        default: begin
          if (w_ss_hi) begin
            r_state <= ST_IDLE;
          end else if (w_byte_done) begin
            case (r_state)
              ST_CMD: begin
                r_ptr <= w_byte[ADDR_W-1:0];
                if (w_byte[CMD_RD_BIT]) begin
                  r_state <= ST_READ;
                  r_re    <= 1'b1;
                  r_addr  <= w_byte[ADDR_W-1:0];
                end else begin
                  r_state <= ST_WRITE;
                end
              end
              ST_WRITE: begin
                r_we    <= 1'b1;
                r_wdata <= w_byte;
                r_addr  <= r_ptr;
                if (AUTOINC) r_ptr <= r_ptr + ADDR_W'(1);
              end
              ST_READ: begin
                r_re   <= 1'b1;
                r_addr <= r_ptr;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.spi_miso    = (r_state == ST_READ) & r_tx[BYTE_W-1];
  assign bus.spi_miso_oe = ~w_ss_level & (r_state != ST_WAIT_SS);
  assign bus.busy        = ~w_ss_level & (r_state != ST_WAIT_SS);
  assign bus.reg_addr    = r_addr;
  assign bus.reg_wdata   = r_wdata;
  assign bus.reg_we      = r_we;
  assign bus.reg_re      = r_re;

endmodule
